// File: rtl/kpn_delay_fifo_if.sv
// kpn_delay_fifo_if
//   Token channel bundle for a KPN delay FIFO: one input (producer -> FIFO)
//   and one output (FIFO -> consumer) valid/ready stream.
//   Ports carried:
//     entry_1 / entry_1_valid / entry_1_ready     input token stream
//     output_1 / output_1_valid / output_1_ready  output token stream
//   Modports:
//     slave  - the FIFO itself
//     master - the surrounding environment (producer and consumer side)
interface kpn_delay_fifo_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] entry_1;
  logic             entry_1_valid;
  logic             entry_1_ready;
  logic [WIDTH-1:0] output_1;
  logic             output_1_valid;
  logic             output_1_ready;

  modport slave (
    input  entry_1,
    input  entry_1_valid,
    output entry_1_ready,
    output output_1,
    output output_1_valid,
    input  output_1_ready
  );

  modport master (
    output entry_1,
    output entry_1_valid,
    input  entry_1_ready,
    input  output_1,
    input  output_1_valid,
    output output_1_ready
  );
endinterface

// File: rtl/kpn_delay_fifo_module.sv
// kpn_delay_fifo_module
//   KPN delay node: a FIFO channel that comes out of reset already holding
//   DELAY_NUMBER tokens of value INIT_VALUE, then forwards accepted input
//   tokens in order. Used for z^-N feedback paths between KPN processes.
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-high; discards contents and reloads the
//              initial tokens
//     io     - token channel (slave side): entry_1* in, output_1* out
//     count  - number of tokens currently stored (0..DEPTH)
//   output_1 is first-word fall-through (combinational read of the head
//   slot). Both ready and valid decode registered count only, so there is
//   no combinational path from output_1_ready to entry_1_ready.
module kpn_delay_fifo_module #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      DEPTH        = 8,
  parameter int unsigned      DELAY_NUMBER = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  kpn_delay_fifo_if.slave              io,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Pointer width; a single-slot FIFO still needs a 1-bit pointer.
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PW-1:0] WR_PTR_INIT = PW'(DELAY_NUMBER % DEPTH);
  localparam logic [CW-1:0] COUNT_INIT  = CW'(DELAY_NUMBER);
  localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST    = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths stay inside 0..DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign io.entry_1_ready  = (count < COUNT_FULL);
  assign io.output_1_valid = (count != '0);
  assign io.output_1       = mem[rd_ptr];

  assign push = io.entry_1_valid  & io.entry_1_ready;
  assign pop  = io.output_1_valid & io.output_1_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_VALUE;
      end
      rd_ptr <= '0;
      wr_ptr <= WR_PTR_INIT;
      count  <= COUNT_INIT;
    end else begin
      if (push) begin
        mem[wr_ptr] <= io.entry_1;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_kpn_delay_fifo_module.sv
module tb_kpn_delay_fifo_module;

  localparam int ND = 3;
  localparam int CAP = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #100 clk = ~clk;

  // Per-DUT stimulus and observed outputs; index 0: DN=4, 1: DN=0, 2: DN=8
  logic        in_valid [ND];
  logic [15:0] in_data  [ND];
  logic        out_ready[ND];
  logic [15:0] o_data   [ND];
  logic        o_valid  [ND];
  logic        i_ready  [ND];
  logic [3:0]  cnt      [ND];

  kpn_delay_fifo_if #(.WIDTH(16)) ifs[ND] ();

  genvar g;
  for (g = 0; g < ND; g++) begin : g_dut
    kpn_delay_fifo_module #(
      .WIDTH       (16),
      .DEPTH       (8),
      .DELAY_NUMBER((g == 0) ? 4 : ((g == 1) ? 0 : 8)),
      .INIT_VALUE  (16'd7)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .io   (ifs[g]),
      .count(cnt[g])
    );
    assign ifs[g].entry_1        = in_data[g];
    assign ifs[g].entry_1_valid  = in_valid[g];
    assign ifs[g].output_1_ready = out_ready[g];
    assign o_data[g]  = ifs[g].output_1;
    assign o_valid[g] = ifs[g].output_1_valid;
    assign i_ready[g] = ifs[g].entry_1_ready;
  end

  // Reference model: one token queue per DUT
  int          dn_of[ND] = '{4, 0, 8};
  logic [15:0] mq[ND][$];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mq[d].delete();
      for (int k = 0; k < dn_of[d]; k++) mq[d].push_back(16'd7);
    end
  endtask

  task automatic set_idle();
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s.d%0d.count", tag, d), 32'(cnt[d]), 32'(mq[d].size()));
      chk($sformatf("%s.d%0d.valid", tag, d), 32'(o_valid[d]), 32'(mq[d].size() != 0));
      chk($sformatf("%s.d%0d.ready", tag, d), 32'(i_ready[d]), 32'(mq[d].size() < CAP));
      if (mq[d].size() != 0)
        chk($sformatf("%s.d%0d.data", tag, d), 32'(o_data[d]), 32'(mq[d][0]));
    end
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic advance();
    bit          do_push[ND];
    bit          do_pop [ND];
    logic [15:0] dat    [ND];
    for (int d = 0; d < ND; d++) begin
      do_push[d] = in_valid[d] && (mq[d].size() < CAP);
      do_pop[d]  = out_ready[d] && (mq[d].size() != 0);
      dat[d]     = in_data[d];
    end
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      if (do_pop[d])  void'(mq[d].pop_front());
      if (do_push[d]) mq[d].push_back(dat[d]);
    end
    @(negedge clk);
  endtask

  // Assert reset between edges; caller may check, then reset_off releases
  // it on a later negedge.
  task automatic reset_on();
    set_idle();
    #30 reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic reset_off();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          iv;
    logic [15:0] d;
    bit          ordy;
    bit          chk_out;
    logic [15:0] e_out;
    bit          e_v;
    bit          e_rdy;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit iv, logic [15:0] d, bit ordy, bit co,
                              logic [15:0] eo, bit ev, bit er, logic [3:0] ec);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.ordy = ordy; v.chk_out = co;
    v.e_out = eo; v.e_v = ev; v.e_rdy = er; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // 1: drain the initial tokens
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 0, 1, 1, 16'd7, 1, 1, 4'(4 - k)));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));
    // 2: fill to full with consumer stalled
    tbl.push_back(mk(1, 1, 1500, 0, 1, 16'd7, 1, 1, 4));
    tbl.push_back(mk(0, 1, 1501, 0, 1, 16'd7, 1, 1, 5));
    tbl.push_back(mk(0, 1, 1502, 0, 1, 16'd7, 1, 1, 6));
    tbl.push_back(mk(0, 1, 1503, 0, 1, 16'd7, 1, 1, 7));
    tbl.push_back(mk(0, 1, 1504, 0, 1, 16'd7, 1, 0, 8));
    tbl.push_back(mk(0, 1, 1505, 0, 1, 16'd7, 1, 0, 8));
    // 3: drain from full
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd7, 1, 0, 8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd7, 1, 1, 7));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd7, 1, 1, 6));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd7, 1, 1, 5));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd1500, 1, 1, 4));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd1501, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd1502, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 16'd1503, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0));

    set_idle();
    #10 reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        reset_on();
        reset_off();
      end
      set_idle();
      in_valid[0] = tbl[i].iv; in_data[0] = tbl[i].d; out_ready[0] = tbl[i].ordy;
      #1;
      if (tbl[i].chk_out) chk($sformatf("vec%0d.out", i), 32'(o_data[0]), 32'(tbl[i].e_out));
      chk($sformatf("vec%0d.valid", i), 32'(o_valid[0]), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d.ready", i), 32'(i_ready[0]), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.count", i), 32'(cnt[0]), 32'(tbl[i].e_cnt));
      check_model($sformatf("vec%0d", i));
      advance();
    end

    // 4: steady stream, one token in and one out every cycle
    reset_on();
    reset_off();
    for (int k = 0; k < 24; k++) begin
      set_idle();
      in_valid[0] = 1'b1; in_data[0] = 16'(2000 + k); out_ready[0] = 1'b1;
      #1;
      chk($sformatf("stream%0d.count", k), 32'(cnt[0]), 32'd4);
      chk($sformatf("stream%0d.out", k), 32'(o_data[0]), (k < 4) ? 32'd7 : 32'(2000 + k - 4));
      check_model($sformatf("stream%0d", k));
      advance();
    end

    // 5: random valid/ready on all three configurations
    for (int c = 0; c < 1000; c++) begin
      for (int d = 0; d < ND; d++) begin
        in_valid[d]  = ($urandom_range(0, 99) < 55);
        in_data[d]   = 16'($urandom);
        out_ready[d] = ($urandom_range(0, 99) < ((c < 500) ? 45 : 65));
      end
      #1;
      check_model($sformatf("rnd%0d", c));
      advance();
    end

    // 6: reset mid-stream with stored data
    reset_on();
    reset_off();
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < ND; d++) begin
        in_valid[d] = 1'b1; in_data[d] = 16'(900 + k); out_ready[d] = 1'b0;
      end
      #1;
      advance();
    end
    set_idle();
    out_ready[2] = 1'b1;
    #1;
    advance();
    set_idle();
    in_valid[2] = 1'b1; in_data[2] = 16'd999;
    #1;
    advance();
    set_idle();
    #1;
    chk("t6.pre.count0", 32'(cnt[0]), 32'd6);
    chk("t6.pre.count8", 32'(cnt[2]), 32'd8);
    reset_on();
    chk("t6.rst.d4.count", 32'(cnt[0]), 32'd4);
    chk("t6.rst.d4.out", 32'(o_data[0]), 32'd7);
    chk("t6.rst.d4.valid", 32'(o_valid[0]), 32'd1);
    chk("t6.rst.d4.ready", 32'(i_ready[0]), 32'd1);
    chk("t6.rst.d0.count", 32'(cnt[1]), 32'd0);
    chk("t6.rst.d0.valid", 32'(o_valid[1]), 32'd0);
    chk("t6.rst.d0.ready", 32'(i_ready[1]), 32'd1);
    chk("t6.rst.d8.count", 32'(cnt[2]), 32'd8);
    chk("t6.rst.d8.out", 32'(o_data[2]), 32'd7);
    chk("t6.rst.d8.valid", 32'(o_valid[2]), 32'd1);
    chk("t6.rst.d8.ready", 32'(i_ready[2]), 32'd0);
    check_model("t6.rst");
    reset_off();
    for (int k = 0; k < 10; k++) begin
      for (int d = 0; d < ND; d++) out_ready[d] = 1'b1;
      #1;
      for (int d = 0; d < ND; d++)
        if (o_valid[d]) chk($sformatf("t6.drain%0d.d%0d.out", k, d), 32'(o_data[d]), 32'd7);
      check_model($sformatf("t6.drain%0d", k));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
